ysyx_22041412_csr_ctrl: RTL and testbench

//  System-instruction controller that sits directly upstream of the machine-CSR unit.
//  It accepts one SYSTEM-opcode instruction (csrrw/s/c[i], ecall, mret) from execute and decodes it.
//  It drives the CSR unit's en/addr/func3/data/pc handshake, waits for ready, then returns the rd writeback value or a PC redirect.

---
 rtl/ysyx_22041412_csr_pkg.sv | 46 ++++
 rtl/ysyx_22041412_csr_decode.sv | 59 +++++
 rtl/ysyx_22041412_csr_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ysyx_22041412_csr_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_csr_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_csr_pkg
// Shared types and constants for the SYSTEM-instruction controller that sits
// in front of the machine-CSR unit.
//   state_e : controller FSM states (IDLE -> ISSUE -> DONE)
//   op_e    : decoded operation class of a SYSTEM instruction
//   CSR_*   : 12-bit architectural CSR addresses recognised by the decoder
//   IDX_*   : 3-bit CSR-unit index driven on csr_addr_o
// ----------------------------------------------------------------------------
package ysyx_22041412_csr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_CSR,
        OP_ECALL,
        OP_MRET,
        OP_ILLEGAL
    } op_e;

    localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;

    localparam logic [11:0] IMM_ECALL   = 12'h000;
    localparam logic [11:0] IMM_MRET    = 12'h302;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0]  IDX_MRET    = 3'd0;
    localparam logic [2:0]  IDX_ECALL   = 3'd1;
    localparam logic [2:0]  IDX_MSTATUS = 3'd2;
    localparam logic [2:0]  IDX_MTVEC   = 3'd3;
    localparam logic [2:0]  IDX_MEPC    = 3'd4;
    localparam logic [2:0]  IDX_MCAUSE  = 3'd5;

    // The csrr?i forms carry a 5-bit unsigned immediate in the rs1 field.
    function automatic logic [63:0] zext_uimm(input logic [4:0] uimm);
        return {59'd0, uimm};
    endfunction

endpackage

// File: rtl/ysyx_22041412_csr_decode.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_csr_decode
// Purely combinational decode of the fields of a SYSTEM instruction.
//   opcode_i  : inst[6:0]
//   func3_i   : inst[14:12]
//   imm_i     : inst[31:20] (CSR address or ecall/mret selector)
//   op_o      : operation class (CSR / ECALL / MRET / ILLEGAL)
//   idx_o     : CSR-unit index for csr_addr_o
//   func3_o   : funct3 forwarded to the CSR unit (000 for ecall/mret)
//   use_imm_o : 1 when the write data is the zero-extended rs1 field
// ----------------------------------------------------------------------------
module ysyx_22041412_csr_decode
    import ysyx_22041412_csr_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  func3_i,
    input  logic [11:0] imm_i,
    output op_e         op_o,
    output logic [2:0]  idx_o,
    output logic [2:0]  func3_o,
    output logic        use_imm_o
);

    // Anything not explicitly recognised falls through as ILLEGAL, including a
    // non-SYSTEM opcode should the caller ever break its guarantee.
    always_comb begin
        op_o  = OP_ILLEGAL;
        idx_o = IDX_MRET;
        if (opcode_i == OPC_SYSTEM) begin
            case (func3_i)
                3'b000: begin
                    if (imm_i == IMM_ECALL) begin
                        op_o  = OP_ECALL;
                        idx_o = IDX_ECALL;
                    end else if (imm_i == IMM_MRET) begin
                        op_o  = OP_MRET;
                        idx_o = IDX_MRET;
                    end
                end
                3'b100: begin
                    op_o = OP_ILLEGAL;
                end
                default: begin
                    case (imm_i)
                        CSR_MSTATUS: begin op_o = OP_CSR; idx_o = IDX_MSTATUS; end
                        CSR_MTVEC:   begin op_o = OP_CSR; idx_o = IDX_MTVEC;   end
                        CSR_MEPC:    begin op_o = OP_CSR; idx_o = IDX_MEPC;    end
                        CSR_MCAUSE:  begin op_o = OP_CSR; idx_o = IDX_MCAUSE;  end
                        default:     op_o = OP_ILLEGAL;
                    endcase
                end
            endcase
        end
    end

    assign func3_o   = func3_i;
    assign use_imm_o = func3_i[2];

endmodule

// File: rtl/ysyx_22041412_csr_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22041412_csr_ctrl
// Accepts one SYSTEM instruction from execute, drives the machine-CSR unit
// handshake and returns either an rd writeback or a PC redirect.
//   clk, rst_n                      : clock, async active-low reset
//   inst_valid_i/inst_ready_o       : instruction offer / controller idle
//   inst_i, pc_i, rs1_data_i        : instruction word, its PC, rs1 value
//   done_o                          : 1-cycle completion pulse
//   rd_we_o, rd_addr_o, rd_data_o   : rd writeback (old CSR value)
//   redirect_o, redirect_pc_o       : PC redirect for ecall/mret
//   illegal_o, err_o                : bad encoding / CSR unit timeout
//   csr_en_o, csr_pc_o, csr_addr_o,
//   csr_func3_o, csr_wdata_o        : request to the CSR unit
//   csr_rdata_i, csr_ready_i        : response from the CSR unit
// ----------------------------------------------------------------------------
module ysyx_22041412_csr_ctrl
    import ysyx_22041412_csr_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic [31:0] inst_i,
    input  logic [63:0] pc_i,
    input  logic [63:0] rs1_data_i,
    output logic        done_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [63:0] rd_data_o,
    output logic        redirect_o,
    output logic [63:0] redirect_pc_o,
    output logic        illegal_o,
    output logic        err_o,
    output logic        csr_en_o,
    output logic [63:0] csr_pc_o,
    output logic [2:0]  csr_addr_o,
    output logic [2:0]  csr_func3_o,
    output logic [63:0] csr_wdata_o,
    input  logic [63:0] csr_rdata_i,
    input  logic        csr_ready_i
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e      state_q;
    op_e         op_q;
    logic [4:0]  rd_q;
    logic [63:0] pc_q;
    logic [2:0]  addr_q;
    logic [2:0]  func3_q;
    logic [63:0] wdata_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic        en_q;
    logic        done_q;
    logic        rd_we_q;
    logic [4:0]  rd_addr_q;
    logic [63:0] rd_data_q;
    logic        redir_q;
    logic [63:0] redir_pc_q;
    logic        illegal_q;
    logic        err_q;

    op_e         dec_op;
    logic [2:0]  dec_idx;
    logic [2:0]  dec_func3;
    logic        dec_use_imm;
    logic [63:0] wdata_d;

    ysyx_22041412_csr_decode u_decode (
        .opcode_i  (inst_i[6:0]),
        .func3_i   (inst_i[14:12]),
        .imm_i     (inst_i[31:20]),
        .op_o      (dec_op),
        .idx_o     (dec_idx),
        .func3_o   (dec_func3),
        .use_imm_o (dec_use_imm)
    );

    assign wdata_d = dec_use_imm ? zext_uimm(inst_i[19:15]) : rs1_data_i;
    assign cnt_d   = cnt_q + CW'(1);

    // Whole controller FSM. Result outputs are pulsed for exactly the DONE
    // cycle by defaulting them to zero on every edge and setting them only on
    // the transition into DONE. In ISSUE the first cycle (cnt_q == 0) ignores
    // csr_ready_i because it may still reflect the previous request; en_q is
    // dropped on the same edge that captures the response so the CSR unit
    // sees en high when it commits and low in DONE, letting it clear ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ILLEGAL;
            rd_q       <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            func3_q    <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            illegal_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            illegal_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (inst_valid_i) begin
                        op_q    <= dec_op;
                        rd_q    <= inst_i[11:7];
                        pc_q    <= pc_i;
                        addr_q  <= dec_idx;
                        func3_q <= dec_func3;
                        wdata_q <= wdata_d;
                        cnt_q   <= '0;
                        if (dec_op == OP_ILLEGAL) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            en_q    <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if ((cnt_q != '0) && csr_ready_i) begin
                        en_q    <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        case (op_q)
                            OP_ECALL, OP_MRET: begin
                                redir_q    <= 1'b1;
                                redir_pc_q <= csr_rdata_i;
                            end
                            default: begin
                                rd_we_q   <= (rd_q != 5'd0);
                                rd_addr_q <= rd_q;
                                rd_data_q <= csr_rdata_i;
                            end
                        endcase
                    end else if (cnt_d == CW'(TIMEOUT_CYC)) begin
                        en_q    <= 1'b0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_ready_o  = (state_q == S_IDLE);
    assign done_o        = done_q;
    assign rd_we_o       = rd_we_q;
    assign rd_addr_o     = rd_addr_q;
    assign rd_data_o     = rd_data_q;
    assign redirect_o    = redir_q;
    assign redirect_pc_o = redir_pc_q;
    assign illegal_o     = illegal_q;
    assign err_o         = err_q;
    assign csr_en_o      = en_q;
    assign csr_pc_o      = pc_q;
    assign csr_addr_o    = addr_q;
    assign csr_func3_o   = func3_q;
    assign csr_wdata_o   = wdata_q;

endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041412_csr_ctrl
// Self-checking bench: a behavioural CSR-unit responder with programmable
// ready latency, an architectural reference model of the CSRs, directed
// scenarios with literal expectations, then randomized traffic.
// ----------------------------------------------------------------------------
module tb_ysyx_22041412_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic        inst_ready_o;
    logic [31:0] inst_i = '0;
    logic [63:0] pc_i = '0;
    logic [63:0] rs1_data_i = '0;
    logic        done_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        redirect_o;
    logic [63:0] redirect_pc_o;
    logic        illegal_o;
    logic        err_o;
    logic        csr_en_o;
    logic [63:0] csr_pc_o;
    logic [2:0]  csr_addr_o;
    logic [2:0]  csr_func3_o;
    logic [63:0] csr_wdata_o;
    logic [63:0] csr_rdata_i;
    logic        csr_ready_i;

    ysyx_22041412_csr_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_valid_i  (inst_valid_i),
        .inst_ready_o  (inst_ready_o),
        .inst_i        (inst_i),
        .pc_i          (pc_i),
        .rs1_data_i    (rs1_data_i),
        .done_o        (done_o),
        .rd_we_o       (rd_we_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_o     (rd_data_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .illegal_o     (illegal_o),
        .err_o         (err_o),
        .csr_en_o      (csr_en_o),
        .csr_pc_o      (csr_pc_o),
        .csr_addr_o    (csr_addr_o),
        .csr_func3_o   (csr_func3_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_rdata_i   (csr_rdata_i),
        .csr_ready_i   (csr_ready_i)
    );

    // Free-running clock and a posedge counter used to time expectations.
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passCount = 0;
    int totalCount = 0;
    bit checkOn = 1'b0;
    bit junkOn = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        totalCount++;
        if (act === req) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Behavioural CSR unit: raises ready unitDelay cycles after it first sees
    // en, commits the access on the edge where en and ready are both high,
    // and drops ready once en goes low. unitNever models a hung unit.
    int          unitDelay = 0;
    bit          unitNever = 1'b0;
    int          uCnt = 0;
    logic        uReady = 1'b0;
    logic [63:0] uCsr [0:5] = '{default: 64'd0};

    always @(posedge clk) begin
        if (!csr_en_o) begin
            uReady <= 1'b0;
            uCnt   <= 0;
        end else if (!uReady) begin
            if (!unitNever && uCnt >= unitDelay) uReady <= 1'b1;
            uCnt <= uCnt + 1;
        end else begin
            if (csr_addr_o == 3'd1) begin
                uCsr[4] <= csr_pc_o;
                uCsr[5] <= 64'hb;
            end else if (csr_addr_o >= 3'd2 && csr_addr_o <= 3'd5) begin
                case (csr_func3_o[1:0])
                    2'b01:   uCsr[csr_addr_o] <= csr_wdata_o;
                    2'b10:   uCsr[csr_addr_o] <= uCsr[csr_addr_o] | csr_wdata_o;
                    2'b11:   uCsr[csr_addr_o] <= uCsr[csr_addr_o] & ~csr_wdata_o;
                    default: ;
                endcase
            end
        end
    end

    // Read data: mret returns mepc, ecall returns mtvec, others their CSR.
    always_comb begin
        csr_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        if (uReady) begin
            case (csr_addr_o)
                3'd0:    csr_rdata_i = uCsr[4];
                3'd1:    csr_rdata_i = uCsr[3];
                3'd2:    csr_rdata_i = uCsr[2];
                3'd3:    csr_rdata_i = uCsr[3];
                3'd4:    csr_rdata_i = uCsr[4];
                3'd5:    csr_rdata_i = uCsr[5];
                default: csr_rdata_i = 64'd0;
            endcase
        end
    end
    assign csr_ready_i = uReady;

    // Architectural reference model and the expectation for the op in flight.
    logic [11:0] csrMap [4] = '{12'h300, 12'h305, 12'h341, 12'h342};
    logic [63:0] refCsr [0:5] = '{default: 64'd0};

    bit          expValid = 1'b0;
    int          expA = 0;
    int          expL = 0;
    logic [2:0]  expAddr, expF3;
    logic [63:0] expWdata, expPc, expRdData, expRedirPc;
    logic [4:0]  expRdAddr;
    logic        expRdWe, expRedir, expIll, expErr;

    int          lastLat = -1;
    logic [2:0]  lastAddr, lastF3;
    logic [63:0] lastWdata, lastRdData, lastRedirPc;
    logic [4:0]  lastRdAddr;
    logic        lastRdWe, lastRedir, lastIll, lastErr;

    function automatic logic [31:0] mkInst(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b1110011};
    endfunction

    // kind: 0 CSR access, 1 ecall, 2 mret, 3 illegal.
    function automatic void refDecode(input logic [31:0] inst, output int kind, output logic [2:0] idx);
        logic [11:0] imm;
        logic [2:0]  f3;
        imm  = inst[31:20];
        f3   = inst[14:12];
        kind = 3;
        idx  = 3'd0;
        if (f3 == 3'b000) begin
            if (imm == 12'h000) begin kind = 1; idx = 3'd1; end
            else if (imm == 12'h302) begin kind = 2; idx = 3'd0; end
        end else if (f3 != 3'b100) begin
            for (int k = 0; k < 4; k++)
                if (imm == csrMap[k]) begin kind = 0; idx = 3'(k + 2); end
        end
    endfunction

    // Per-cycle comparison of every output against the in-flight expectation.
    // ISSUE occupies cycles expA .. expA+expL-1 and DONE is cycle expA+expL.
    always @(negedge clk) begin
        if (checkOn && rst_n) begin
            automatic bit inEn   = expValid && cyc >= expA && cyc < expA + expL;
            automatic bit isDone = expValid && cyc == expA + expL;
            automatic bit busy   = expValid && cyc >= expA && cyc <= expA + expL;
            checkOutput("inst_ready", inst_ready_o, !busy);
            checkOutput("csr_en", csr_en_o, inEn);
            checkOutput("done", done_o, isDone);
            if (inEn) begin
                checkOutput("csr_addr", csr_addr_o, expAddr);
                checkOutput("csr_func3", csr_func3_o, expF3);
                checkOutput("csr_wdata", csr_wdata_o, expWdata);
                checkOutput("csr_pc", csr_pc_o, expPc);
                lastAddr  = csr_addr_o;
                lastF3    = csr_func3_o;
                lastWdata = csr_wdata_o;
            end
            if (isDone) begin
                checkOutput("rd_we", rd_we_o, expRdWe);
                checkOutput("rd_addr", rd_addr_o, expRdAddr);
                checkOutput("rd_data", rd_data_o, expRdData);
                checkOutput("redirect", redirect_o, expRedir);
                checkOutput("redirect_pc", redirect_pc_o, expRedirPc);
                checkOutput("illegal", illegal_o, expIll);
                checkOutput("err", err_o, expErr);
                lastLat     = cyc - expA;
                lastRdWe    = rd_we_o;
                lastRdAddr  = rd_addr_o;
                lastRdData  = rd_data_o;
                lastRedir   = redirect_o;
                lastRedirPc = redirect_pc_o;
                lastIll     = illegal_o;
                lastErr     = err_o;
                expValid    = 1'b0;
            end else begin
                checkOutput("idle_rd_we", rd_we_o, 0);
                checkOutput("idle_redirect", redirect_o, 0);
                checkOutput("idle_illegal", illegal_o, 0);
                checkOutput("idle_err", err_o, 0);
            end
        end
    end

    // Offers one instruction (holding junk on the bus while busy if junkOn),
    // records the model's expectation and updates the reference CSRs.
    task automatic applyStimulus(input logic [31:0] inst, input logic [63:0] pc,
                                 input logic [63:0] rs1, input int delay, input bit never);
        int waitN = 0;
        int kind;
        logic [2:0] idx;
        logic [63:0] w, old;
        while (!inst_ready_o && waitN < 60) begin
            inst_valid_i = junkOn;
            inst_i       = $urandom;
            rs1_data_i   = {$urandom, $urandom};
            pc_i         = {$urandom, $urandom};
            @(negedge clk); #1;
            waitN++;
        end
        if (!inst_ready_o) begin
            totalCount++;
            $display("[TB] FAIL accept_wait: inst_ready_o stuck at 0, expected 1 within 60 cycles");
        end
        unitDelay = delay;
        unitNever = never;
        refDecode(inst, kind, idx);
        expA       = cyc + 1;
        expAddr    = idx;
        expF3      = inst[14:12];
        w          = inst[14] ? {59'd0, inst[19:15]} : rs1;
        expWdata   = w;
        expPc      = pc;
        expRdWe    = 1'b0;
        expRdAddr  = 5'd0;
        expRdData  = 64'd0;
        expRedir   = 1'b0;
        expRedirPc = 64'd0;
        expIll     = 1'b0;
        expErr     = 1'b0;
        if (kind == 3) begin
            expL   = 0;
            expIll = 1'b1;
        end else if (never || delay > 14) begin
            expL   = 16;
            expErr = 1'b1;
        end else begin
            expL = 2 + delay;
            case (kind)
                1: begin
                    expRedir   = 1'b1;
                    expRedirPc = refCsr[3];
                    refCsr[4]  = pc;
                    refCsr[5]  = 64'hb;
                end
                2: begin
                    expRedir   = 1'b1;
                    expRedirPc = refCsr[4];
                end
                default: begin
                    old       = refCsr[idx];
                    expRdAddr = inst[11:7];
                    expRdWe   = (inst[11:7] != 5'd0);
                    expRdData = old;
                    case (inst[13:12])
                        2'b01:   refCsr[idx] = w;
                        2'b10:   refCsr[idx] = old | w;
                        default: refCsr[idx] = old & ~w;
                    endcase
                end
            endcase
        end
        expValid     = 1'b1;
        inst_valid_i = 1'b1;
        inst_i       = inst;
        pc_i         = pc;
        rs1_data_i   = rs1;
        @(negedge clk); #1;
        inst_valid_i = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (expValid && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (expValid) begin
            totalCount++;
            $display("[TB] FAIL done_wait: done_o never seen, expected within 40 cycles");
            expValid = 1'b0;
        end
    endtask

    initial begin
        int r, d;
        bit nv;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [2:0]  f3List [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

        // Reset state while rst_n is held low.
        #1;
        checkOutput("reset_inst_ready", inst_ready_o, 1);
        checkOutput("reset_csr_en", csr_en_o, 0);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_rd_we", rd_we_o, 0);
        checkOutput("reset_redirect", redirect_o, 0);
        checkOutput("reset_err", err_o, 0);
        checkOutput("reset_csr_wdata", csr_wdata_o, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        checkOn = 1'b1;

        // csrrw x5, mtvec, x6 with rs1 = 0x8000_0100.
        applyStimulus(mkInst(12'h305, 5'd6, 3'b001, 5'd5), 64'h8000_0000, 64'h8000_0100, 0, 0);
        waitDone();
        checkOutput("csrrw_addr", lastAddr, 3);
        checkOutput("csrrw_func3", lastF3, 3'b001);
        checkOutput("csrrw_latency", lastLat, 2);
        checkOutput("csrrw_rd_we", lastRdWe, 1);
        checkOutput("csrrw_rd_addr", lastRdAddr, 5);
        checkOutput("csrrw_rd_data", lastRdData, 0);
        applyStimulus(mkInst(12'h305, 5'd0, 3'b010, 5'd7), 64'h8000_0004, 64'd0, 1, 0);
        waitDone();
        checkOutput("mtvec_readback", lastRdData, 64'h8000_0100);

        // csrrsi x0, mstatus, 5 then read mstatus back.
        applyStimulus(mkInst(12'h300, 5'd5, 3'b110, 5'd0), 64'h8000_0008, 64'hFFFF_0000_1234_5678, 0, 0);
        waitDone();
        checkOutput("csrrsi_wdata", lastWdata, 64'h5);
        checkOutput("csrrsi_rd_we", lastRdWe, 0);
        applyStimulus(mkInst(12'h300, 5'd0, 3'b010, 5'd1), 64'h8000_000c, 64'd0, 0, 0);
        waitDone();
        checkOutput("mstatus_readback", lastRdData, 64'h5);

        // ecall at 0x8000_0040, then read mepc and mcause.
        applyStimulus(32'h0000_0073, 64'h8000_0040, 64'd0, 2, 0);
        waitDone();
        checkOutput("ecall_redirect", lastRedir, 1);
        checkOutput("ecall_redirect_pc", lastRedirPc, 64'h8000_0100);
        applyStimulus(mkInst(12'h341, 5'd0, 3'b010, 5'd2), 64'h8000_0100, 64'd0, 0, 0);
        waitDone();
        checkOutput("mepc_readback", lastRdData, 64'h8000_0040);
        applyStimulus(mkInst(12'h342, 5'd0, 3'b010, 5'd3), 64'h8000_0104, 64'd0, 0, 0);
        waitDone();
        checkOutput("mcause_readback", lastRdData, 64'hb);

        // mret returns to mepc.
        applyStimulus(32'h3020_0073, 64'h8000_0108, 64'd0, 0, 0);
        waitDone();
        checkOutput("mret_redirect_pc", lastRedirPc, 64'h8000_0040);
        checkOutput("mret_rd_we", lastRdWe, 0);

        // Unsupported CSR address.
        applyStimulus(mkInst(12'h7c0, 5'd2, 3'b001, 5'd1), 64'h8000_0044, 64'd1, 0, 0);
        waitDone();
        checkOutput("illegal_flag", lastIll, 1);
        checkOutput("illegal_latency", lastLat, 0);

        // Hung CSR unit.
        applyStimulus(mkInst(12'h341, 5'd2, 3'b001, 5'd1), 64'h8000_0048, 64'd7, 0, 1);
        waitDone();
        checkOutput("timeout_err", lastErr, 1);
        checkOutput("timeout_latency", lastLat, 16);

        // Asynchronous reset in the middle of ISSUE.
        checkOn = 1'b0;
        unitNever = 1'b0;
        unitDelay = 3;
        while (!inst_ready_o) begin @(negedge clk); #1; end
        inst_valid_i = 1'b1;
        inst_i       = mkInst(12'h341, 5'd2, 3'b001, 5'd1);
        rs1_data_i   = 64'h1234;
        @(negedge clk); #1;
        inst_valid_i = 1'b0;
        checkOutput("midreset_pre_en", csr_en_o, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_csr_en", csr_en_o, 0);
        checkOutput("midreset_inst_ready", inst_ready_o, 1);
        checkOutput("midreset_done", done_o, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        expValid = 1'b0;
        @(negedge clk); #1;
        checkOn = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 99);
            d  = $urandom_range(0, 9);
            d  = (d < 7) ? $urandom_range(0, 3) : ((d == 7) ? 14 : ((d == 8) ? 15 : 0));
            nv = ($urandom_range(0, 19) == 0);
            junkOn = $urandom_range(0, 1);
            f3  = f3List[$urandom_range(0, 5)];
            imm = csrMap[$urandom_range(0, 3)];
            if (r < 62) begin
                if (r >= 55) imm = 12'($urandom);
            end else if (r < 72) begin
                f3 = 3'b000; imm = 12'h000;
            end else if (r < 82) begin
                f3 = 3'b000; imm = 12'h302;
            end else if (r < 88) begin
                f3 = 3'b000; imm = 12'($urandom);
            end else if (r < 93) begin
                f3 = 3'b100;
            end else begin
                f3 = 3'($urandom); imm = 12'($urandom);
            end
            applyStimulus(mkInst(imm, 5'($urandom), f3, 5'($urandom)),
                          {$urandom, $urandom}, {$urandom, $urandom}, d, nv);
        end
        junkOn = 1'b0;
        waitDone();
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
